// File: rtl/game_pkg.sv
// Shared constants and FSM state encoding for the sprite motion control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    localparam int SCREEN_WIDTH    = 640;
    localparam int SCREEN_HEIGHT   = 480;
    localparam int X_WIDTH         = 10;
    localparam int Y_WIDTH         = 10;
    // Wide enough for the largest legal update period (255 frames).
    localparam int FRAME_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/game_sprite_control_if.sv
// Bundles the sprite control strobes, load values and registered position outputs.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is accepted in the cycle it is presented.
interface game_sprite_control_if #(
    parameter int X_WIDTH  = game_pkg::X_WIDTH,
    parameter int Y_WIDTH  = game_pkg::Y_WIDTH,
    parameter int DX_WIDTH = 4,
    parameter int DY_WIDTH = 4
);

    logic                frame_start;
    logic                sprite_write_xy;
    logic [X_WIDTH-1:0]  sprite_write_x;
    logic [Y_WIDTH-1:0]  sprite_write_y;
    logic                sprite_write_dxdy;
    logic [DX_WIDTH-1:0] sprite_write_dx;
    logic [DY_WIDTH-1:0] sprite_write_dy;
    logic                sprite_enable_update;
    logic                sprite_out_of_screen;
    logic [X_WIDTH-1:0]  sprite_x;
    logic [Y_WIDTH-1:0]  sprite_y;
    logic                sprite_halted;

    // Driver side: game logic / display stage feeding the controller.
    modport master (
        output frame_start, sprite_write_xy, sprite_write_x, sprite_write_y,
               sprite_write_dxdy, sprite_write_dx, sprite_write_dy,
               sprite_enable_update, sprite_out_of_screen,
        input  sprite_x, sprite_y, sprite_halted
    );

    // Controller side.
    modport slave (
        input  frame_start, sprite_write_xy, sprite_write_x, sprite_write_y,
               sprite_write_dxdy, sprite_write_dx, sprite_write_dy,
               sprite_enable_update, sprite_out_of_screen,
        output sprite_x, sprite_y, sprite_halted
    );

endinterface

// File: rtl/game_strobe_divider.sv
// Counts strobe pulses and emits a combinational tick on every PERIOD-th pulse.
// Latency: tick is same-cycle with the qualifying strobe; count updates on the next edge.
// Backpressure: none; clear holds the count at zero and masks the tick.
module game_strobe_divider
    import game_pkg::*;
#(
    parameter int PERIOD = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic strobe,
    output logic tick
);

    localparam logic [FRAME_CNT_WIDTH-1:0] LAST = FRAME_CNT_WIDTH'(PERIOD - 1);

    logic [FRAME_CNT_WIDTH-1:0] cnt;

    assign tick = strobe && !clear && (cnt == LAST);

    // Frame counter: held at zero while cleared, wraps to zero on each tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= (cnt == LAST) ? '0 : cnt + FRAME_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/game_sprite_control.sv
// Moves a sprite by a signed velocity once every UPDATE_PERIOD frames, halting when it leaves the screen.
// Latency: every effect is visible one clock after the causing input edge.
// Backpressure: none; position/velocity loads are always accepted and a load beats a coincident update.
module game_sprite_control #(
    parameter int X_WIDTH       = game_pkg::X_WIDTH,
    parameter int Y_WIDTH       = game_pkg::Y_WIDTH,
    parameter int DX_WIDTH      = 4,
    parameter int DY_WIDTH      = 4,
    parameter int UPDATE_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    game_sprite_control_if.slave  bus
);

    game_pkg::state_t state_q;
    game_pkg::state_t state_d;

    logic                       tick;
    logic                       halted_q;
    logic                       apply_move;
    logic [X_WIDTH-1:0]         x_q;
    logic [X_WIDTH-1:0]         x_d;
    logic [Y_WIDTH-1:0]         y_q;
    logic [Y_WIDTH-1:0]         y_d;
    logic signed [DX_WIDTH-1:0] dx_q;
    logic signed [DY_WIDTH-1:0] dy_q;

    // Frame pulses outside MOVE are dropped: the divider is cleared there.
    game_strobe_divider #(
        .PERIOD (UPDATE_PERIOD)
    ) u_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != game_pkg::ST_MOVE),
        .strobe  (bus.frame_start),
        .tick    (tick)
    );

    // State register; halted flag is registered alongside so it tracks the state exactly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= game_pkg::ST_IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == game_pkg::ST_HALT);
        end
    end

    // Next state: disable and position loads outrank the off-screen halt on a tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            game_pkg::ST_IDLE: begin
                if (bus.sprite_enable_update && !bus.sprite_write_xy) begin
                    state_d = game_pkg::ST_MOVE;
                end
            end
            game_pkg::ST_MOVE: begin
                if (!bus.sprite_enable_update) begin
                    state_d = game_pkg::ST_IDLE;
                end else if (tick && bus.sprite_out_of_screen && !bus.sprite_write_xy) begin
                    state_d = game_pkg::ST_HALT;
                end
            end
            game_pkg::ST_HALT: begin
                if (bus.sprite_write_xy) begin
                    state_d = game_pkg::ST_IDLE;
                end
            end
            default: state_d = game_pkg::ST_IDLE;
        endcase
    end

    // Next position: a load always wins; otherwise step by the current velocity on a clean tick.
    always_comb begin
        apply_move = (state_q == game_pkg::ST_MOVE) && tick && bus.sprite_enable_update &&
                     !bus.sprite_write_xy && !bus.sprite_out_of_screen;
        x_d = x_q;
        y_d = y_q;
        if (bus.sprite_write_xy) begin
            x_d = bus.sprite_write_x;
            y_d = bus.sprite_write_y;
        end else if (apply_move) begin
            // Signed casts sign-extend the velocity; the sum wraps at the coordinate width.
            x_d = x_q + X_WIDTH'(dx_q);
            y_d = y_q + Y_WIDTH'(dy_q);
        end
    end

    // Position and velocity registers; a velocity load lands after the old value was used.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q  <= '0;
            y_q  <= '0;
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (bus.sprite_write_dxdy) begin
                dx_q <= bus.sprite_write_dx;
                dy_q <= bus.sprite_write_dy;
            end
        end
    end

    assign bus.sprite_x      = x_q;
    assign bus.sprite_y      = y_q;
    assign bus.sprite_halted = halted_q;

endmodule
